// File: rtl/grad_bram.sv
// OCRA gradient waveform buffer: host loads an 8192x32 BRAM over AXI4-Lite and the
// block streams it to the gradient serialiser at a programmable period.

module grad_bram_regs (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [12:0] wr_idx,
   input  logic [31:0] wr_data,
   input  logic [3:0]  wr_strb,
   input  logic [12:0] rd_idx,
   input  logic        err_set,
   output logic [31:0] rd_data,
   output logic [9:0]  rate
);
   logic [9:0]  reg0;
   logic [31:0] reg1, reg2, reg3;
   logic        err;

   function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] res;
      res = cur;
      for (int b = 0; b < 4; b++)
         if (be[b]) res[8*b +: 8] = wd[8*b +: 8];
      return res;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg0 <= 10'd303;
         reg1 <= '0;
         reg2 <= '0;
         reg3 <= '0;
         err  <= 1'b0;
      end else begin
         if (err_set) err <= 1'b1;
         if (wr_en) begin
            case (wr_idx)
               13'd0: begin
                  if (wr_strb[0]) reg0[7:0] <= wr_data[7:0];
                  if (wr_strb[1]) reg0[9:8] <= wr_data[9:8];
               end
               13'd1:   reg1 <= merge(reg1, wr_data, wr_strb);
               13'd2:   reg2 <= merge(reg2, wr_data, wr_strb);
               13'd3:   reg3 <= merge(reg3, wr_data, wr_strb);
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      rd_data = '0;
      case (rd_idx)
         13'd0:   rd_data = {22'd0, reg0};
         13'd1:   rd_data = reg1;
         13'd2:   rd_data = reg2;
         13'd3:   rd_data = reg3;
         13'd4:   rd_data = {31'd0, err};
         default: rd_data = '0;
      endcase
   end

   assign rate = reg0;
endmodule

module grad_bram_mem (
   input  logic        clk,
   input  logic        wr_en,
   input  logic [12:0] wr_addr,
   input  logic [31:0] wr_data,
   input  logic [3:0]  wr_strb,
   input  logic        rd_en,
   input  logic [12:0] rd_addr,
   output logic [31:0] rd_data
);
   logic [31:0] mem [0:8191];

   always_ff @(posedge clk) begin
      if (wr_en)
         for (int b = 0; b < 4; b++)
            if (wr_strb[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
   end

   always_ff @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end
endmodule

// state   | meaning
// ST_IDLE | stream stopped, waiting for a data_enb_i rising edge
// ST_RUN  | period counter running, BRAM fetch on terminal count
module grad_bram #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 16
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESETN,
   input  logic [15:0]                       offset_i,
   input  logic                              data_enb_i,
   input  logic                              serial_busy_i,
   output logic [31:0]                       data_o,
   output logic                              valid_o,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY
);
   typedef enum logic {ST_IDLE, ST_RUN} st_t;

   logic        clk, rst_n;
   logic        aw_rdy, b_vld, ar_rdy, r_vld;
   logic [31:0] r_data;
   logic        wr_commit, rd_accept;
   logic [31:0] reg_rd;
   logic [9:0]  rate;
   logic        err_set;

   st_t         st, st_nxt;
   logic        enb_q, start, issue;
   logic [10:0] cnt;
   logic [12:0] ptr;
   logic        fetch_v, pend;
   logic [31:0] pend_data, mem_q;
   logic        xfer;
   logic        unused_bits;

   assign clk   = S_AXI_ACLK;
   assign rst_n = S_AXI_ARESETN;

   // Address and data are both sampled on the single cycle the ready pulse is high.
   assign wr_commit = aw_rdy & S_AXI_AWVALID & S_AXI_WVALID;
   assign rd_accept = ar_rdy & S_AXI_ARVALID;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_rdy <= 1'b0;
         b_vld  <= 1'b0;
         ar_rdy <= 1'b0;
         r_vld  <= 1'b0;
         r_data <= '0;
      end else begin
         aw_rdy <= S_AXI_AWVALID & S_AXI_WVALID & ~b_vld & ~aw_rdy;
         if (wr_commit)         b_vld <= 1'b1;
         else if (S_AXI_BREADY) b_vld <= 1'b0;
         ar_rdy <= S_AXI_ARVALID & ~r_vld & ~ar_rdy;
         if (rd_accept) begin
            r_vld  <= 1'b1;
            r_data <= S_AXI_ARADDR[15] ? 32'd0 : reg_rd;
         end else if (S_AXI_RREADY) begin
            r_vld <= 1'b0;
         end
      end
   end

   assign S_AXI_AWREADY = aw_rdy;
   assign S_AXI_WREADY  = aw_rdy;
   assign S_AXI_BVALID  = b_vld;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_ARREADY = ar_rdy;
   assign S_AXI_RVALID  = r_vld;
   assign S_AXI_RDATA   = r_data;
   assign S_AXI_RRESP   = 2'b00;

   grad_bram_regs u_regs (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_commit & ~S_AXI_AWADDR[15]),
      .wr_idx  (S_AXI_AWADDR[14:2]),
      .wr_data (S_AXI_WDATA),
      .wr_strb (S_AXI_WSTRB),
      .rd_idx  (S_AXI_ARADDR[14:2]),
      .err_set (err_set),
      .rd_data (reg_rd),
      .rate    (rate)
   );

   grad_bram_mem u_mem (
      .clk     (clk),
      .wr_en   (wr_commit & S_AXI_AWADDR[15]),
      .wr_addr (S_AXI_AWADDR[14:2]),
      .wr_data (S_AXI_WDATA),
      .wr_strb (S_AXI_WSTRB),
      .rd_en   (issue),
      .rd_addr (ptr),
      .rd_data (mem_q)
   );

   assign start = data_enb_i & ~enb_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= ST_IDLE;
      else        st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      issue  = 1'b0;
      case (st)
         ST_IDLE: if (start) st_nxt = ST_RUN;
         ST_RUN: begin
            if (!data_enb_i) st_nxt = ST_IDLE;
            else             issue  = (cnt == 11'd0);
         end
         default: st_nxt = ST_IDLE;
      endcase
   end

   assign xfer    = data_enb_i & pend & ~serial_busy_i;
   // A fetch landing on a word the serialiser never took means that word is lost.
   assign err_set = data_enb_i & fetch_v & pend & serial_busy_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enb_q     <= 1'b0;
         cnt       <= '0;
         ptr       <= '0;
         fetch_v   <= 1'b0;
         pend      <= 1'b0;
         pend_data <= '0;
         data_o    <= '0;
         valid_o   <= 1'b0;
      end else begin
         enb_q   <= data_enb_i;
         valid_o <= 1'b0;
         if (start) begin
            ptr <= offset_i[12:0];
            cnt <= '0;
         end else if (issue) begin
            ptr <= ptr + 13'd1;
            cnt <= {1'b0, rate} + 11'd3;
         end else if (st == ST_RUN && cnt != 11'd0) begin
            cnt <= cnt - 11'd1;
         end
         if (!data_enb_i) begin
            fetch_v <= 1'b0;
            pend    <= 1'b0;
         end else begin
            fetch_v <= issue;
            if (fetch_v) begin
               pend      <= 1'b1;
               pend_data <= mem_q;
            end else if (xfer) begin
               pend <= 1'b0;
            end
            if (xfer) begin
               data_o  <= pend_data;
               valid_o <= 1'b1;
            end
         end
      end
   end

   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                          S_AXI_ARADDR[1:0], offset_i[15:13]};
endmodule

// File: tb/tb_grad_bram.sv
// Randomised scoreboard bench for grad_bram: AXI register/BRAM traffic plus stream
// data, spacing, back-pressure, restart and reset behaviour against a reference model.

module tb_grad_bram;
   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [15:0] offset;
   logic        enb, busy;
   logic [31:0] data_o;
   logic        valid_o;
   logic [15:0] awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   grad_bram dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
      .offset_i(offset), .data_enb_i(enb), .serial_busy_i(busy),
      .data_o(data_o), .valid_o(valid_o),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
      .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
      .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp),
      .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr),
      .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
      .S_AXI_RREADY(rready)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [31:0] m_mem [0:8191];
   logic [31:0] m_reg [0:3];
   logic        m_err;
   logic [31:0] rd_q[$];
   logic [31:0] s_q[$];
   logic [31:0] mon_exp;
   bit          s_chk = 1'b1;
   int          s_period = 0;
   int          s_last = -1;
   int          s_count = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out, expected DUT response (t=%0t)", name, $time);
   endtask

   function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = cur;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic model_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
      if (a[15]) m_mem[a[14:2]] = merge(m_mem[a[14:2]], d, s);
      else if (a[14:2] < 13'd4) begin
         m_reg[a[3:2]] = merge(m_reg[a[3:2]], d, s);
         if (a[3:2] == 2'd0) m_reg[0] = m_reg[0] & 32'h3FF;
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [15:0] a);
      if (a[15]) return 32'd0;
      if (a[14:2] < 13'd4) return m_reg[a[3:2]];
      if (a[14:2] == 13'd4) return {31'd0, m_err};
      return 32'd0;
   endfunction

   task automatic load_stream(input int off);
      s_q.delete();
      for (int i = 0; i < 8192; i++) s_q.push_back(m_mem[(off + i) % 8192]);
      s_last = -1;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (rvalid && rready) begin
            if (rd_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rd_unexpected: got %h expected no response", rdata);
            end else begin
               mon_exp = rd_q.pop_front();
               check("axi_rdata", rdata, mon_exp);
               check("axi_rresp", {30'd0, rresp}, 32'd0);
            end
         end
         if (bvalid && bready) check("axi_bresp", {30'd0, bresp}, 32'd0);
         if (valid_o) begin
            if (s_chk) begin
               if (s_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL stream_unexpected: got %h expected no word", data_o);
               end else begin
                  mon_exp = s_q.pop_front();
                  check("stream_data", data_o, mon_exp);
               end
               if (s_period != 0 && s_last >= 0) check("stream_period", cyc - s_last, s_period);
            end
            s_last = cyc;
            s_count++;
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_pulses(input int n, input int budget);
      int target, c;
      target = s_count + n;
      c = 0;
      while (s_count < target && c < budget) begin @(posedge clk); #1; c++; end
      if (s_count < target) timeout("stream_pulse_wait");
   endtask

   task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
      int n;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      while (!(awready && wready) && n < 20) begin @(posedge clk); #1; n++; end
      if (n >= 20) timeout("axi_aw_ready");
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      model_write(a, d, s);
      n = 0;
      while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
      if (n >= 20) timeout("axi_bvalid");
      @(posedge clk); #1;
   endtask

   task automatic axi_read(input logic [15:0] a);
      int n;
      rd_q.push_back(exp_read(a));
      araddr = a; arvalid = 1'b1;
      n = 0;
      while (!arready && n < 20) begin @(posedge clk); #1; n++; end
      if (n >= 20) timeout("axi_ar_ready");
      @(posedge clk); #1;
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
      if (n >= 20) timeout("axi_rvalid");
      @(posedge clk); #1;
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] a;
      logic [12:0] idx;
      rst_n = 1'b0; offset = '0; enb = 1'b0; busy = 1'b0;
      awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; wdata = '0; wstrb = '0;
      bready = 1'b1; rready = 1'b1;
      m_reg[0] = 32'd303; m_reg[1] = '0; m_reg[2] = '0; m_reg[3] = '0; m_err = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_axi_ctrl", {25'd0, awready, wready, bvalid, arready, rvalid, |bresp, |rresp}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_data_o", data_o, 32'd0);
      check("rst_valid_o", {31'd0, valid_o}, 32'd0);
      rst_n = 1'b1;
      wait_cyc(1);

      axi_write(16'h0004, 32'hDEADBEEF, 4'hF);
      axi_write(16'h0008, 32'hCAFEBABE, 4'hF);
      axi_write(16'h000C, 32'hABCD0123, 4'hF);
      axi_write(16'h0010, 32'h12345678, 4'hF);
      axi_read(16'h0000);
      axi_read(16'h0004);
      axi_read(16'h0008);
      axi_read(16'h000C);
      axi_read(16'h0010);

      for (int i = 0; i < 12; i++) begin
         idx = 13'($urandom_range(0, 5));
         if (idx == 13'd5) idx = 13'($urandom_range(5, 8191));
         a = {1'b0, idx, 2'($urandom)};
         axi_write(a, $urandom, 4'($urandom));
         axi_read({1'b0, idx, 2'($urandom)});
      end
      axi_read(16'h8000 + 16'($urandom_range(0, 8191) * 4));

      for (int k = 0; k <= 8192; k++) axi_write(16'(32'h8000 + 4 * k), k, 4'hF);
      axi_read(16'h0000);
      for (int i = 0; i < 16; i++)
         axi_write(16'(32'h8000 + 4 * $urandom_range(0, 39)), $urandom, 4'($urandom));

      axi_write(16'h0000, 32'd303, 4'hF);
      offset = 16'd0;
      load_stream(0);
      s_period = 307;
      enb = 1'b1;
      wait_pulses(4, 2000);

      axi_write(16'h0000, 32'd0, 4'hF);
      s_period = 0;
      wait_pulses(2, 1000);
      s_period = 4;
      for (int i = 0; i < 8; i++) axi_write(16'(32'h8000 + 4 * (4000 + i)), $urandom, 4'hF);
      wait_pulses(4, 100);
      axi_write(16'h0000, 32'd303, 4'hF);
      s_period = 0;
      wait_pulses(2, 1000);
      s_period = 307;
      wait_pulses(2, 1000);

      s_period = 0;
      wait_pulses(1, 1000);
      wait_cyc(100);
      busy = 1'b1;
      wait_cyc(300);
      busy = 1'b0;
      wait_pulses(2, 1000);
      axi_read(16'h0010);

      wait_pulses(1, 1000);
      busy = 1'b1;
      wait_cyc(317);
      enb = 1'b0;
      offset = 16'd10;
      wait_cyc(1);
      load_stream(10);
      busy = 1'b0;
      enb = 1'b1;
      s_period = 307;
      wait_pulses(3, 1500);
      axi_read(16'h0010);

      s_chk = 1'b0;
      busy = 1'b1;
      wait_cyc(1000);
      busy = 1'b0;
      wait_cyc(20);
      m_err = 1'b1;
      axi_read(16'h0010);
      enb = 1'b0;
      wait_cyc(2);

      axi_write(16'h0000, 32'd0, 4'hF);
      offset = 16'd8190;
      load_stream(8190);
      s_chk = 1'b1;
      s_period = 4;
      enb = 1'b1;
      wait_cyc(3);
      offset = 16'($urandom);
      wait_pulses(6, 200);

      enb = 1'b0;
      wait_cyc(1);
      offset = 16'd3998;
      load_stream(3998);
      enb = 1'b1;
      wait_pulses(12, 200);

      offset = 16'd100;
      wait_pulses(4, 200);
      rst_n = 1'b0;
      load_stream(100);
      m_reg[0] = 32'd303; m_reg[1] = '0; m_reg[2] = '0; m_reg[3] = '0; m_err = 1'b0;
      s_period = 307;
      #1;
      check("midrst_data_o", data_o, 32'd0);
      check("midrst_valid_o", {31'd0, valid_o}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_pulses(3, 1500);
      axi_read(16'h0000);
      axi_read(16'h0010);
      axi_read(16'h0004);

      wait_cyc(5);
      check("rd_q_drained", rd_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
